// File: rtl/ofs_plat_axi_mem_rd_arb_pkg.sv
// Shared sizing helpers for the AXI-MM read arbiter and its round-robin primitive.
// Pure functions only: no latency, no flow control.
package ofs_plat_axi_mem_rd_arb_pkg;

    // Width of a source index; never below 1 so vectors stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a per-source burst counter able to hold 0..max_out inclusive.
    function automatic int cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/ofs_plat_prim_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a registered pointer, combinational.
// Latency 0 for grant; the pointer moves past the winner only when i_en accepts the grant.
module ofs_plat_prim_rr_arbiter
    import ofs_plat_axi_mem_rd_arb_pkg::*;
#(
    parameter int N = 4
)(
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_grant,
    output logic         o_adv
);

    localparam int IW = idx_w(N);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_gidx;
    logic [IW:0]   w_pos;
    logic          w_any;

    // Walk N positions starting at r_ptr, wrapping modulo N; the first request wins.
    always_comb begin
        o_grant = '0;
        w_gidx  = '0;
        w_pos   = '0;
        w_any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            if (!w_any && i_req[w_pos[IW-1:0]]) begin
                w_any                  = 1'b1;
                o_grant[w_pos[IW-1:0]] = 1'b1;
                w_gidx                 = w_pos[IW-1:0];
            end
        end
    end

    assign o_adv = i_en && w_any;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (o_adv) begin
            r_ptr <= (w_gidx == IW'(N - 1)) ? '0 : w_gidx + IW'(1);
        end
    end

endmodule

// File: rtl/ofs_plat_axi_mem_rd_arb.sv
// Shares one AXI-MM AR/R channel pair among N_SOURCES requesters with per-source burst credits.
// AR: 1-cycle registered, held stable under sink stall; R: 0-cycle demux, stalls on the owner's rready.
module ofs_plat_axi_mem_rd_arb
    import ofs_plat_axi_mem_rd_arb_pkg::*;
#(
    parameter int N_SOURCES       = 4,
    parameter int ADDR_WIDTH      = 48,
    parameter int LEN_WIDTH       = 8,
    parameter int SRC_ID_WIDTH    = 4,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 16,
    localparam int IDX_W          = idx_w(N_SOURCES),
    localparam int RID_W          = SRC_ID_WIDTH + IDX_W
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_SOURCES-1:0]           src_arvalid,
    input  logic [N_SOURCES*ADDR_WIDTH-1:0] src_araddr,
    input  logic [N_SOURCES*LEN_WIDTH-1:0] src_arlen,
    input  logic [N_SOURCES*SRC_ID_WIDTH-1:0] src_arid,
    output logic [N_SOURCES-1:0]           src_arready,
    output logic                           sink_arvalid,
    output logic [ADDR_WIDTH-1:0]          sink_araddr,
    output logic [LEN_WIDTH-1:0]           sink_arlen,
    output logic [RID_W-1:0]               sink_arid,
    input  logic                           sink_arready,
    input  logic                           sink_rvalid,
    input  logic [RID_W-1:0]               sink_rid,
    input  logic [DATA_WIDTH-1:0]          sink_rdata,
    input  logic                           sink_rlast,
    output logic                           sink_rready,
    output logic [N_SOURCES-1:0]           src_rvalid,
    output logic [SRC_ID_WIDTH-1:0]        src_rid,
    output logic [DATA_WIDTH-1:0]          src_rdata,
    output logic                           src_rlast,
    input  logic [N_SOURCES-1:0]           src_rready,
    output logic                           err_bad_rid
);

    localparam int CNT_W = cnt_w(MAX_OUTSTANDING);

    logic [CNT_W-1:0]        r_cnt [N_SOURCES];
    logic                    r_arvalid;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [LEN_WIDTH-1:0]    r_arlen;
    logic [RID_W-1:0]        r_arid;
    logic                    r_err;

    logic [N_SOURCES-1:0]    w_elig;
    logic [N_SOURCES-1:0]    w_grant;
    logic [N_SOURCES-1:0]    w_inc;
    logic [N_SOURCES-1:0]    w_dec;
    logic [N_SOURCES-1:0]    w_r_sel;
    logic [N_SOURCES-1:0]    w_cnt_zero;
    logic                    w_slot_free;
    logic                    w_adv;
    logic [IDX_W-1:0]        w_gidx;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [LEN_WIDTH-1:0]    w_sel_len;
    logic [SRC_ID_WIDTH-1:0] w_sel_id;
    logic [IDX_W-1:0]        w_ridx;
    logic                    w_bad_idx;
    logic                    w_rready;
    logic                    w_rlast_hs;
    logic                    w_underflow;

    // Eligibility uses the registered count, so a same-cycle rlast cannot unmask a full source.
    always_comb begin
        w_elig     = '0;
        w_cnt_zero = '0;
        for (int i = 0; i < N_SOURCES; i++) begin
            w_elig[i]     = src_arvalid[i] && (r_cnt[i] < CNT_W'(MAX_OUTSTANDING));
            w_cnt_zero[i] = (r_cnt[i] == '0);
        end
    end

    assign w_slot_free = !r_arvalid || sink_arready;

    ofs_plat_prim_rr_arbiter #(
        .N (N_SOURCES)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .i_req   (w_elig),
        .i_en    (w_slot_free),
        .o_grant (w_grant),
        .o_adv   (w_adv)
    );

    assign src_arready = reset ? '0 : (w_grant & {N_SOURCES{w_slot_free}});

    always_comb begin
        w_gidx     = '0;
        w_sel_addr = '0;
        w_sel_len  = '0;
        w_sel_id   = '0;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (w_grant[i]) begin
                w_gidx     = IDX_W'(i);
                w_sel_addr = src_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_len  = src_arlen[i*LEN_WIDTH +: LEN_WIDTH];
                w_sel_id   = src_arid[i*SRC_ID_WIDTH +: SRC_ID_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arid    <= '0;
        end else if (w_slot_free) begin
            r_arvalid <= w_adv;
            if (w_adv) begin
                r_araddr <= w_sel_addr;
                r_arlen  <= w_sel_len;
                r_arid   <= {w_gidx, w_sel_id};
            end
        end
    end

    assign sink_arvalid = r_arvalid;
    assign sink_araddr  = r_araddr;
    assign sink_arlen   = r_arlen;
    assign sink_arid    = r_arid;

    assign w_ridx = sink_rid[RID_W-1 -: IDX_W];

    // Index codes past the last source only exist when N_SOURCES is not a power of two.
    generate
        if ((1 << IDX_W) != N_SOURCES) begin : g_bad_idx
            assign w_bad_idx = (w_ridx >= IDX_W'(N_SOURCES));
        end else begin : g_no_bad_idx
            assign w_bad_idx = 1'b0;
        end
    endgenerate

    always_comb begin
        w_r_sel = '0;
        for (int i = 0; i < N_SOURCES; i++) begin
            w_r_sel[i] = (w_ridx == IDX_W'(i));
        end
    end

    // Beats for an unknown index are swallowed so the sink never wedges.
    assign w_rready    = reset ? 1'b0 : (w_bad_idx || |(w_r_sel & src_rready));
    assign sink_rready = w_rready;
    assign src_rvalid  = (sink_rvalid && !reset) ? w_r_sel : '0;
    assign src_rid     = sink_rid[SRC_ID_WIDTH-1:0];
    assign src_rdata   = sink_rdata;
    assign src_rlast   = sink_rlast;

    assign w_rlast_hs  = sink_rvalid && w_rready && sink_rlast;
    assign w_inc       = w_adv ? w_grant : '0;
    assign w_dec       = w_rlast_hs ? w_r_sel : '0;
    assign w_underflow = |(w_dec & w_cnt_zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SOURCES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SOURCES; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i] && !w_cnt_zero[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((sink_rvalid && w_bad_idx) || w_underflow) begin
            r_err <= 1'b1;
        end
    end

    assign err_bad_rid = r_err;

endmodule

// File: tb/tb_ofs_plat_axi_mem_rd_arb.sv
// Bench for the AXI read arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_ofs_plat_axi_mem_rd_arb;

    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int LW   = 8;
    localparam int SW   = 4;
    localparam int DW   = 32;
    localparam int MAXO = 2;
    localparam int IW   = 2;
    localparam int RW   = SW + IW;
    localparam int N3   = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    src_arvalid;
    logic [N*AW-1:0] src_araddr;
    logic [N*LW-1:0] src_arlen;
    logic [N*SW-1:0] src_arid;
    logic [N-1:0]    src_arready;
    logic            sink_arvalid;
    logic [AW-1:0]   sink_araddr;
    logic [LW-1:0]   sink_arlen;
    logic [RW-1:0]   sink_arid;
    logic            sink_arready;
    logic            sink_rvalid;
    logic [RW-1:0]   sink_rid;
    logic [DW-1:0]   sink_rdata;
    logic            sink_rlast;
    logic            sink_rready;
    logic [N-1:0]    src_rvalid;
    logic [SW-1:0]   src_rid;
    logic [DW-1:0]   src_rdata;
    logic            src_rlast;
    logic [N-1:0]    src_rready;
    logic            err_bad_rid;

    logic [N3-1:0]    t3_src_arvalid;
    logic [N3*AW-1:0] t3_src_araddr;
    logic [N3*LW-1:0] t3_src_arlen;
    logic [N3*SW-1:0] t3_src_arid;
    logic [N3-1:0]    t3_src_arready;
    logic             t3_sink_arvalid;
    logic [AW-1:0]    t3_sink_araddr;
    logic [LW-1:0]    t3_sink_arlen;
    logic [RW-1:0]    t3_sink_arid;
    logic             t3_sink_arready;
    logic             t3_sink_rvalid;
    logic [RW-1:0]    t3_sink_rid;
    logic [DW-1:0]    t3_sink_rdata;
    logic             t3_sink_rlast;
    logic             t3_sink_rready;
    logic [N3-1:0]    t3_src_rvalid;
    logic [SW-1:0]    t3_src_rid;
    logic [DW-1:0]    t3_src_rdata;
    logic             t3_src_rlast;
    logic [N3-1:0]    t3_src_rready;
    logic             t3_err_bad_rid;

    ofs_plat_axi_mem_rd_arb #(
        .N_SOURCES(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SRC_ID_WIDTH(SW),
        .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .src_arvalid(src_arvalid), .src_araddr(src_araddr), .src_arlen(src_arlen),
        .src_arid(src_arid), .src_arready(src_arready),
        .sink_arvalid(sink_arvalid), .sink_araddr(sink_araddr), .sink_arlen(sink_arlen),
        .sink_arid(sink_arid), .sink_arready(sink_arready),
        .sink_rvalid(sink_rvalid), .sink_rid(sink_rid), .sink_rdata(sink_rdata),
        .sink_rlast(sink_rlast), .sink_rready(sink_rready),
        .src_rvalid(src_rvalid), .src_rid(src_rid), .src_rdata(src_rdata),
        .src_rlast(src_rlast), .src_rready(src_rready), .err_bad_rid(err_bad_rid)
    );

    ofs_plat_axi_mem_rd_arb #(
        .N_SOURCES(N3), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SRC_ID_WIDTH(SW),
        .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut3 (
        .clk(clk), .reset(reset),
        .src_arvalid(t3_src_arvalid), .src_araddr(t3_src_araddr), .src_arlen(t3_src_arlen),
        .src_arid(t3_src_arid), .src_arready(t3_src_arready),
        .sink_arvalid(t3_sink_arvalid), .sink_araddr(t3_sink_araddr), .sink_arlen(t3_sink_arlen),
        .sink_arid(t3_sink_arid), .sink_arready(t3_sink_arready),
        .sink_rvalid(t3_sink_rvalid), .sink_rid(t3_sink_rid), .sink_rdata(t3_sink_rdata),
        .sink_rlast(t3_sink_rlast), .sink_rready(t3_sink_rready),
        .src_rvalid(t3_src_rvalid), .src_rid(t3_src_rid), .src_rdata(t3_src_rdata),
        .src_rlast(t3_src_rlast), .src_rready(t3_src_rready), .err_bad_rid(t3_err_bad_rid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bitof(input logic [N-1:0] v, input int j);
        return ((v >> j) & N'(1)) != '0;
    endfunction

    // Reference model: outstanding bursts per source, RR pointer, the AR slot and the error flag.
    int            m_cnt [N];
    int            m_ptr;
    bit            m_vld;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    logic [RW-1:0] m_id;
    bit            m_err;

    logic [N-1:0]  ar_acc_seen;
    bit            r_hs_seen;
    int            pq_id [$];
    int            pq_len [$];
    int            r_beat;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr = 0; m_vld = 0; m_addr = '0; m_len = '0; m_id = '0; m_err = 0;
    endtask

    always @(negedge clk) begin : cmp_blk
        int g;
        int ridx;
        int dec;
        bit slot;
        bit exp_rrdy;
        logic [N-1:0] exp_ardy;
        logic [N-1:0] exp_rv;
        ar_acc_seen = src_arvalid & src_arready;
        r_hs_seen   = sink_rvalid && sink_rready;
        if (sink_arvalid && sink_arready) begin
            pq_id.push_back(int'(sink_arid));
            pq_len.push_back(int'(sink_arlen));
        end
        if (reset) begin
            model_reset();
        end else begin
            slot = !m_vld || sink_arready;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && bitof(src_arvalid, (m_ptr + k) % N) && m_cnt[(m_ptr + k) % N] < MAXO)
                    g = (m_ptr + k) % N;
            end
            exp_ardy = (slot && g >= 0) ? (N'(1) << g) : '0;
            ridx     = int'(sink_rid >> SW);
            exp_rv   = sink_rvalid ? (N'(1) << ridx) : '0;
            exp_rrdy = bitof(src_rready, ridx);

            check("src_arready", src_arready, exp_ardy);
            check("sink_arvalid", sink_arvalid, m_vld);
            if (m_vld) begin
                check("sink_araddr", sink_araddr, m_addr);
                check("sink_arlen", sink_arlen, m_len);
                check("sink_arid", sink_arid, m_id);
            end
            check("src_rvalid", src_rvalid, exp_rv);
            check("sink_rready", sink_rready, exp_rrdy);
            if (sink_rvalid) begin
                check("src_rid", src_rid, sink_rid[SW-1:0]);
                check("src_rdata", src_rdata, sink_rdata);
                check("src_rlast", src_rlast, sink_rlast);
            end
            check("err_bad_rid", err_bad_rid, m_err);

            if (exp_ardy != '0) begin
                m_vld  = 1;
                m_addr = AW'(src_araddr >> (g * AW));
                m_len  = LW'(src_arlen >> (g * LW));
                m_id   = {IW'(g), SW'(src_arid >> (g * SW))};
                m_ptr  = (g + 1) % N;
            end else if (sink_arready) begin
                m_vld = 0;
            end
            dec = -1;
            if (sink_rvalid && exp_rrdy && sink_rlast) begin
                if (m_cnt[ridx] == 0) m_err = 1;
                else dec = ridx;
            end
            if (exp_ardy != '0) m_cnt[g]++;
            if (dec >= 0) m_cnt[dec]--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        src_arvalid = '0; src_araddr = '0; src_arlen = '0; src_arid = '0;
        sink_arready = 1'b0; sink_rvalid = 1'b0; sink_rid = '0; sink_rdata = '0;
        sink_rlast = 1'b0; src_rready = '0;
        t3_src_arvalid = '0; t3_src_araddr = '0; t3_src_arlen = '0; t3_src_arid = '0;
        t3_sink_arready = 1'b0; t3_sink_rvalid = 1'b0; t3_sink_rid = '0; t3_sink_rdata = '0;
        t3_sink_rlast = 1'b0; t3_src_rready = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        zero_inputs();
        pq_id.delete();
        pq_len.delete();
        r_beat = 0;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [SW-1:0] id);
        src_araddr[i*AW +: AW] = a;
        src_arlen[i*LW +: LW]  = l;
        src_arid[i*SW +: SW]   = id;
    endtask

    // Sink-side R responder: in-order bursts from the issued-AR queue, holds each beat until taken.
    task automatic r_step();
        if (sink_rvalid && r_hs_seen) begin
            if (sink_rlast) begin
                void'(pq_id.pop_front());
                void'(pq_len.pop_front());
                r_beat = 0;
            end else begin
                r_beat++;
            end
            sink_rvalid = 1'b0;
        end
        if (!sink_rvalid && pq_id.size() > 0 && $urandom_range(0, 3) != 0) begin
            sink_rvalid = 1'b1;
            sink_rid    = RW'(pq_id[0]);
            sink_rlast  = (r_beat == pq_len[0]);
            sink_rdata  = $urandom;
        end
    endtask

    initial begin
        zero_inputs();
        r_beat = 0;
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        src_arvalid = '1;
        #1;
        check("rst_src_arready", src_arready, 0);
        check("rst_sink_arvalid", sink_arvalid, 0);
        check("rst_err", err_bad_rid, 0);
        src_arvalid = '0;
        tick();
        reset = 1'b0;

        // Round-robin across four always-valid sources.
        for (int i = 0; i < N; i++) set_src(i, AW'(16'h1000 + i), LW'(i), SW'(i + 5));
        src_arvalid  = '1;
        sink_arready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t1_grant", src_arready, 4'b0001 << (k % 4));
            if (k > 0) check("t1_arid_src", sink_arid[RW-1 -: IW], (k - 1) % 4);
            tick();
        end
        @(negedge clk);
        check("t1_last_src", sink_arid[RW-1 -: IW], 0);
        check("t1_last_addr", sink_araddr, 16'h1000);
        tick();
        do_reset();

        // Sink stall holds the AR register.
        set_src(2, 16'h2222, 8'd3, 4'h7);
        src_arvalid = 4'b0100;
        @(negedge clk);
        check("t2_first_grant", src_arready, 4'b0100);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_stall_ardy", src_arready, 0);
            check("t2_hold_vld", sink_arvalid, 1);
            check("t2_hold_addr", sink_araddr, 16'h2222);
            check("t2_hold_id", sink_arid, {2'd2, 4'h7});
            tick();
        end
        sink_arready = 1'b1;
        @(negedge clk);
        check("t2_release", src_arready, 4'b0100);
        tick();
        do_reset();

        // Credit limit on source 1, released by one rlast.
        set_src(1, 16'h3000, 8'd0, 4'h1);
        src_arvalid  = 4'b0010;
        sink_arready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t3_grant", src_arready, 4'b0010);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t3_blocked", src_arready, 0);
            tick();
        end
        sink_rvalid = 1'b1; sink_rid = {2'd1, 4'h1}; sink_rlast = 1'b1;
        sink_rdata  = 32'hCAFE0001; src_rready = 4'b0010;
        @(negedge clk);
        check("t3_rvalid", src_rvalid, 4'b0010);
        check("t3_same_cycle_blocked", src_arready, 0);
        tick();
        sink_rvalid = 1'b0;
        @(negedge clk);
        check("t3_unblocked", src_arready, 4'b0010);
        tick();
        do_reset();

        // R backpressure from the owning source, then counter decrement exposed by an underflow.
        src_arvalid  = 4'b0100;
        sink_arready = 1'b1;
        tick();
        src_arvalid = '0;
        tick();
        sink_rvalid = 1'b1; sink_rid = {2'd2, 4'h5}; sink_rlast = 1'b1;
        sink_rdata  = 32'h0BAD_F00D; src_rready = '0;
        @(negedge clk);
        check("t4_rvalid", src_rvalid, 4'b0100);
        check("t4_rready_low", sink_rready, 0);
        check("t4_rid", src_rid, 4'h5);
        tick();
        src_rready = 4'b0100;
        @(negedge clk);
        check("t4_rready_high", sink_rready, 1);
        tick();
        sink_rvalid = 1'b0;
        @(negedge clk);
        check("t4_no_err", err_bad_rid, 0);
        tick();
        sink_rvalid = 1'b1;
        tick();
        sink_rvalid = 1'b0;
        @(negedge clk);
        check("t4_underflow_err", err_bad_rid, 1);
        tick();

        // Unknown source index on a three-source instance.
        @(negedge clk);
        check("t5_err_before", t3_err_bad_rid, 0);
        tick();
        t3_sink_rvalid = 1'b1; t3_sink_rid = {2'd3, 4'h1}; t3_sink_rlast = 1'b1;
        @(negedge clk);
        check("t5_rready_forced", t3_sink_rready, 1);
        check("t5_no_rvalid", t3_src_rvalid, 0);
        tick();
        t3_sink_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_err_sticky", t3_err_bad_rid, 1);
            tick();
        end
        do_reset();
        @(negedge clk);
        check("t5_err_cleared", t3_err_bad_rid, 0);
        tick();

        // Reset with four bursts in flight, then a stray rlast.
        src_arvalid  = '1;
        sink_arready = 1'b1;
        repeat (4) tick();
        src_arvalid = '0;
        sink_rvalid = 1'b1; sink_rid = {2'd0, 4'h0}; sink_rlast = 1'b1; src_rready = '1;
        #1;
        reset = 1'b1;
        src_arvalid = '1;
        #1;
        check("t6_async_arvalid", sink_arvalid, 0);
        check("t6_async_arready", src_arready, 0);
        check("t6_async_rvalid", src_rvalid, 0);
        check("t6_async_rready", sink_rready, 0);
        zero_inputs();
        pq_id.delete();
        pq_len.delete();
        tick();
        reset = 1'b0;
        sink_rvalid = 1'b1; sink_rid = {2'd0, 4'h0}; sink_rlast = 1'b1; src_rready = '1;
        @(negedge clk);
        check("t6_stray_rvalid", src_rvalid, 4'b0001);
        tick();
        sink_rvalid  = 1'b0;
        src_arvalid  = 4'b0001;
        sink_arready = 1'b1;
        @(negedge clk);
        check("t6_stray_err", err_bad_rid, 1);
        check("t6_cnt_grant0", src_arready, 4'b0001);
        tick();
        @(negedge clk);
        check("t6_cnt_grant1", src_arready, 4'b0001);
        tick();
        @(negedge clk);
        check("t6_cnt_full", src_arready, 0);
        tick();
        do_reset();

        // Randomized traffic with an in-order responding sink.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bitof(src_arvalid, i) || bitof(ar_acc_seen, i)) begin
                    if ($urandom_range(0, 1) == 1) src_arvalid = src_arvalid | (N'(1) << i);
                    else src_arvalid = src_arvalid & ~(N'(1) << i);
                    set_src(i, AW'($urandom), LW'($urandom_range(0, 3)), SW'($urandom));
                end
            end
            sink_arready = ($urandom_range(0, 3) != 0);
            src_rready   = N'($urandom);
            r_step();
            tick();
        end
        src_arvalid  = '0;
        sink_arready = 1'b1;
        src_rready   = '1;
        for (int c = 0; c < 2000 && (pq_id.size() > 0 || sink_rvalid || sink_arvalid); c++) begin
            r_step();
            tick();
        end
        check("drain_pending", pq_id.size(), 0);
        check("drain_err", err_bad_rid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
